prog_ticker: RTL

Programmable tick generator. It succeeds the fixed-period 10000 divider used to slow the board clock for display and counter logic. Period width and reset-default period are parametrised, and the period can be reloaded at run time through a shadow register. It adds an enable, a periodic/one-shot mode with a start strobe, a busy flag and a running tick counter. It sits between the system clock and any block needing a slow strobe, such as display refresh, debounce or counter advance.

---
 rtl/prog_ticker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prog_ticker.sv
// Programmable tick generator: counts period_act+1 enabled cycles per interval and
// emits a registered one-cycle tick, in periodic or one-shot mode, with a shadowed period reload.
module prog_ticker #(
    parameter int W              = 20,
    parameter int DEFAULT_PERIOD = 10000,
    parameter int CW             = 16
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          enable,
    input  logic          mode,
    input  logic          start,
    input  logic          period_ld,
    input  logic [W-1:0]  period_in,
    output logic          tick,
    output logic          busy,
    output logic [W-1:0]  count,
    output logic [CW-1:0] tick_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0]  PERIOD_RST = W'(DEFAULT_PERIOD);
    localparam logic [W-1:0]  ZERO_W     = {W{1'b0}};
    localparam logic [W-1:0]  ONE_W      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_CW    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CW     = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r, state_s;
    logic [W-1:0]  count_r, count_s;
    logic          tick_r, tick_s;
    logic [CW-1:0] tick_cnt_r, tick_cnt_s;
    logic [W-1:0]  period_act_r, period_act_s;
    logic [W-1:0]  period_shadow_r, period_shadow_s;
    logic          pending_r, pending_s;
    logic          interval_end_s;
    logic          restart_s;

    assign interval_end_s = enable & (count_r == period_act_r);
    assign restart_s      = start & ~mode;

    // Next-state and next-value logic for the interval FSM and its datapath
    always_comb begin
        state_s         = state_r;
        count_s         = count_r;
        tick_s          = 1'b0;
        tick_cnt_s      = tick_cnt_r;
        period_act_s    = period_act_r;
        period_shadow_s = period_shadow_r;
        pending_s       = pending_r;

        // A same-cycle load is folded into the shadow first so that any apply below sees it
        if (period_ld) begin
            period_shadow_s = period_in;
            pending_s       = 1'b1;
        end else begin
            period_shadow_s = period_shadow_r;
        end

        case (state_r)
            ST_IDLE: begin
                count_s = ZERO_W;
                if (pending_s) begin
                    period_act_s = period_shadow_s;
                    pending_s    = 1'b0;
                end else begin
                    period_act_s = period_act_r;
                end
                if (start || !mode) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (interval_end_s || restart_s) begin
                    count_s = ZERO_W;
                    if (pending_s) begin
                        period_act_s = period_shadow_s;
                        pending_s    = 1'b0;
                    end else begin
                        period_act_s = period_act_r;
                    end
                    // An interval end takes precedence over a coincident start
                    if (interval_end_s) begin
                        tick_s     = 1'b1;
                        tick_cnt_s = tick_cnt_r + ONE_CW;
                        state_s    = mode ? ST_IDLE : ST_RUN;
                    end else begin
                        tick_s     = 1'b0;
                        tick_cnt_s = tick_cnt_r;
                    end
                end else if (enable) begin
                    count_s = count_r + ONE_W;
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                count_s = ZERO_W;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r         <= mode ? ST_IDLE : ST_RUN;
            count_r         <= ZERO_W;
            tick_r          <= 1'b0;
            tick_cnt_r      <= ZERO_CW;
            period_act_r    <= PERIOD_RST;
            period_shadow_r <= PERIOD_RST;
            pending_r       <= 1'b0;
        end else begin
            state_r         <= state_s;
            count_r         <= count_s;
            tick_r          <= tick_s;
            tick_cnt_r      <= tick_cnt_s;
            period_act_r    <= period_act_s;
            period_shadow_r <= period_shadow_s;
            pending_r       <= pending_s;
        end
    end

    assign tick     = tick_r;
    assign busy     = (state_r == ST_RUN);
    assign count    = count_r;
    assign tick_cnt = tick_cnt_r;

endmodule
